// File: rtl/sr_original_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_original_pkg
//  Description : Shared constants and types for the FME 8x8 pixel row bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_original_pkg;

   localparam int DATAWIDTH_DEFAULT = 8;   // bits per pixel
   localparam int ROWS              = 8;   // rows held in the bank
   localparam int COLS              = 8;   // pixels per row

   // One row at the default pixel width; element 0 is the leftmost pixel.
   typedef logic [COLS-1:0][DATAWIDTH_DEFAULT-1:0] row_t;

endpackage : sr_original_pkg
`default_nettype wire

// File: rtl/sr_row_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_row_reg
//  Description : One 8-pixel row register with synchronous active-low reset
//                and a load enable. Chained eight times to form the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_row_reg
   import sr_original_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           i_enable,
   input  logic [COLS-1:0][DATAWIDTH-1:0] i_row,
   output logic [COLS-1:0][DATAWIDTH-1:0] o_row
);

   logic [COLS-1:0][DATAWIDTH-1:0] r_row;

   // Clear on reset, otherwise capture the incoming row when enabled.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_row <= '0;
      end else if (i_enable) begin
         r_row <= i_row;
      end
   end

   assign o_row = r_row;

endmodule : sr_row_reg
`default_nettype wire

// File: rtl/sr_original.sv
`default_nettype none
// ============================================================================
//  Module      : sr_original
//  Description : 8x8 pixel row-bank shift register. Load mode shifts a new
//                row in at r0; read mode rotates r7 back into r0. The two
//                oldest rows (r7, r6) are presented every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_original
   import sr_original_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 enable_read,
   input  logic [DATAWIDTH-1:0] in_0,
   input  logic [DATAWIDTH-1:0] in_1,
   input  logic [DATAWIDTH-1:0] in_2,
   input  logic [DATAWIDTH-1:0] in_3,
   input  logic [DATAWIDTH-1:0] in_4,
   input  logic [DATAWIDTH-1:0] in_5,
   input  logic [DATAWIDTH-1:0] in_6,
   input  logic [DATAWIDTH-1:0] in_7,
   output logic [DATAWIDTH-1:0] out_0,
   output logic [DATAWIDTH-1:0] out_1,
   output logic [DATAWIDTH-1:0] out_2,
   output logic [DATAWIDTH-1:0] out_3,
   output logic [DATAWIDTH-1:0] out_4,
   output logic [DATAWIDTH-1:0] out_5,
   output logic [DATAWIDTH-1:0] out_6,
   output logic [DATAWIDTH-1:0] out_7,
   output logic [DATAWIDTH-1:0] out_8,
   output logic [DATAWIDTH-1:0] out_9,
   output logic [DATAWIDTH-1:0] out_10,
   output logic [DATAWIDTH-1:0] out_11,
   output logic [DATAWIDTH-1:0] out_12,
   output logic [DATAWIDTH-1:0] out_13,
   output logic [DATAWIDTH-1:0] out_14,
   output logic [DATAWIDTH-1:0] out_15
);

   // w_d[i] feeds row register i, w_q[i] is its stored value.
   logic [COLS-1:0][DATAWIDTH-1:0] w_d [ROWS];
   logic [COLS-1:0][DATAWIDTH-1:0] w_q [ROWS];
   logic [COLS-1:0][DATAWIDTH-1:0] w_in_row;

   // in_0 lands in element 0 so it stays the leftmost pixel.
   assign w_in_row = {in_7, in_6, in_5, in_4, in_3, in_2, in_1, in_0};

   // Head of the chain: new row in load mode, recirculated oldest row in read mode.
   assign w_d[0] = enable_read ? w_q[ROWS-1] : w_in_row;

   generate
      for (genvar gi = 1; gi < ROWS; gi++) begin : g_chain
         assign w_d[gi] = w_q[gi-1];
      end

      for (genvar gr = 0; gr < ROWS; gr++) begin : g_rows
         sr_row_reg #(
            .DATAWIDTH (DATAWIDTH)
         ) u_row (
            .clock    (clock),
            .reset    (reset),
            .i_enable (enable),
            .i_row    (w_d[gr]),
            .o_row    (w_q[gr])
         );
      end
   endgenerate

   // Oldest row on out_0..7, second-oldest on out_8..15, straight from registers.
   assign out_0  = w_q[ROWS-1][0];
   assign out_1  = w_q[ROWS-1][1];
   assign out_2  = w_q[ROWS-1][2];
   assign out_3  = w_q[ROWS-1][3];
   assign out_4  = w_q[ROWS-1][4];
   assign out_5  = w_q[ROWS-1][5];
   assign out_6  = w_q[ROWS-1][6];
   assign out_7  = w_q[ROWS-1][7];
   assign out_8  = w_q[ROWS-2][0];
   assign out_9  = w_q[ROWS-2][1];
   assign out_10 = w_q[ROWS-2][2];
   assign out_11 = w_q[ROWS-2][3];
   assign out_12 = w_q[ROWS-2][4];
   assign out_13 = w_q[ROWS-2][5];
   assign out_14 = w_q[ROWS-2][6];
   assign out_15 = w_q[ROWS-2][7];

endmodule : sr_original
`default_nettype wire

// File: tb/tb_sr_original.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_original
//  Description : Scoreboard bench for sr_original. A queue-based row-bank
//                model predicts the 16 output pixels after every edge; a
//                monitor compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_original;
   import sr_original_pkg::*;

   typedef logic [15:0][7:0] outv_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       enable_read = 1'b0;
   logic [7:0] din  [8];
   logic [7:0] dout [16];

   row_t       bank [$];      // bank[0] = newest row (r0), bank[7] = oldest (r7)
   outv_t      exp_q [$];
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clock = ~clock;

   sr_original #(.DATAWIDTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .enable_read (enable_read),
      .in_0 (din[0]), .in_1 (din[1]), .in_2 (din[2]), .in_3 (din[3]),
      .in_4 (din[4]), .in_5 (din[5]), .in_6 (din[6]), .in_7 (din[7]),
      .out_0  (dout[0]),  .out_1  (dout[1]),  .out_2  (dout[2]),  .out_3  (dout[3]),
      .out_4  (dout[4]),  .out_5  (dout[5]),  .out_6  (dout[6]),  .out_7  (dout[7]),
      .out_8  (dout[8]),  .out_9  (dout[9]),  .out_10 (dout[10]), .out_11 (dout[11]),
      .out_12 (dout[12]), .out_13 (dout[13]), .out_14 (dout[14]), .out_15 (dout[15])
   );

   // Row k, column j = 16k + j + 4.
   function automatic row_t pat(input int k);
      row_t r;
      for (int j = 0; j < 8; j++) r[j] = 8'(16 * k + j + 4);
      return r;
   endfunction

   function automatic row_t rnd_row();
      row_t r;
      r = {$urandom, $urandom};
      return r;
   endfunction

   // Drive one cycle, then advance the reference model and queue its prediction.
   task automatic cyc(input logic rst, input logic en, input logic rd, input row_t row);
      row_t  tmp;
      outv_t e;
      @(negedge clock);
      reset = rst; enable = en; enable_read = rd;
      for (int j = 0; j < 8; j++) din[j] = row[j];
      @(posedge clock);
      if (!rst) begin
         bank = {};
         for (int i = 0; i < 8; i++) bank.push_back('0);
      end else if (en) begin
         if (rd) begin
            tmp = bank.pop_back();
            bank.push_front(tmp);
         end else begin
            bank.push_front(row);
            tmp = bank.pop_back();
         end
      end
      for (int j = 0; j < 8; j++) begin
         e[j]     = bank[7][j];
         e[8 + j] = bank[6][j];
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare each predicted output vector shortly after its edge.
   initial begin
      outv_t e;
      outv_t a;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int j = 0; j < 16; j++) a[j] = dout[j];
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs vec=%0d t=%0t got=%h expected=%h", vectors, $time, a, e);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) bank.push_back('0);
      for (int j = 0; j < 8; j++) din[j] = '0;

      // Reset with arbitrary enables.
      cyc(1'b0, 1'b1, 1'b1, rnd_row());
      // Load rows 0..7, then rotate a full period plus one.
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, pat(k));
      for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b1, rnd_row());
      // Hold with changing inputs and toggling read.
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'(k & 1), rnd_row());
      // Reset mid-rotation, partial load of 3 rows, then more shifting.
      cyc(1'b1, 1'b1, 1'b1, rnd_row());
      cyc(1'b0, 1'b1, 1'b1, rnd_row());
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, pat(k));
      for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, rnd_row());
      // Reset during read, then full reload.
      cyc(1'b0, 1'b1, 1'b1, rnd_row());
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b0, pat(k));
      // Read-to-load switch mid-rotation.
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b1, rnd_row());
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, rnd_row());
      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
             1'($urandom), rnd_row());
      end

      repeat (3) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sr_original
`default_nettype wire
